// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush generator: mul/div occupancy, load-use, cache-miss stalls,
// branch redirects and exception flushes, with a remembered redirect under icache miss.
module hazard_ctrl #(
    parameter int DIV_LAT = 32,
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_read_rs,
    input  logic       d_read_rt,
    input  logic [4:0] e_writereg,
    input  logic       e_regwrite,
    input  logic       e_mem_read,
    input  logic       e_is_mfc,
    input  logic       e_divmul_start,
    input  logic       e_is_div,
    input  logic       e_redirect,
    input  logic       icache_stall,
    input  logic       dcache_stall,
    input  logic       m_except,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       flush_w,
    output logic       divmul_busy,
    output logic       redirect_pending
);
    localparam logic [5:0] DIV_M1 = 6'(DIV_LAT - 1);
    localparam logic [5:0] MUL_M1 = 6'(MUL_LAT - 1);

    logic [5:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       pend_q, pend_d;

    logic       start, busy, lu, exc_go, blocked;
    logic [5:0] lat_m1;
    logic       sf, sd, se, sm, fd, fe, fm, fw;

    always_comb begin
        start   = e_divmul_start & (cnt_q == 6'd0) & ~done_q;
        busy    = start | (cnt_q != 6'd0);
        lu      = (e_mem_read | e_is_mfc) & e_regwrite & (e_writereg != 5'd0) &
                  ((d_read_rs & (d_rs == e_writereg)) | (d_read_rt & (d_rt == e_writereg)));
        exc_go  = m_except & ~dcache_stall;
        blocked = dcache_stall | busy | lu;
        lat_m1  = e_is_div ? DIV_M1 : MUL_M1;
    end

    // Priority chain; the trailing pend branch is the one-shot discard of the wrong-path fetch.
    always_comb begin
        {sf, sd, se, sm, fd, fe, fm, fw} = 8'b0;
        if (exc_go) begin
            {fd, fe, fm, fw} = 4'b1111;
        end else if (dcache_stall) begin
            {sf, sd, se, sm, fw} = 5'b11111;
        end else if (busy) begin
            {sf, sd, se, fm} = 4'b1111;
        end else if (lu) begin
            {sf, sd, fe} = 3'b111;
        end else if (e_redirect) begin
            {fd, fe} = 2'b11;
        end else if (icache_stall) begin
            {sf, fd} = 2'b11;
        end else if (pend_q) begin
            fd = 1'b1;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        pend_d = pend_q;
        if (exc_go) begin
            cnt_d  = 6'd0;
            done_d = 1'b0;
            pend_d = 1'b0;
        end else begin
            if (start) begin
                cnt_d  = lat_m1;
                done_d = (lat_m1 == 6'd0);
            end else if (cnt_q != 6'd0) begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) done_d = 1'b1;
            end else if (!se) begin
                done_d = 1'b0;
            end
            if (!blocked) begin
                if (e_redirect && icache_stall) pend_d = 1'b1;
                else if (!icache_stall)         pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= 6'd0;
            done_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        stall_f          = resetn & sf;
        stall_d          = resetn & sd;
        stall_e          = resetn & se;
        stall_m          = resetn & sm;
        flush_d          = resetn & fd;
        flush_e          = resetn & fe;
        flush_m          = resetn & fm;
        flush_w          = resetn & fw;
        divmul_busy      = resetn & busy;
        redirect_pending = resetn & pend_q;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: rule-level model compared every cycle plus
// directed vectors with hand-computed literal expectations.
module tb_hazard_ctrl;
    localparam int DIV_LAT = 32;
    localparam int MUL_LAT = 2;

    localparam logic [9:0] SF  = 10'b10_0000_0000;
    localparam logic [9:0] SD  = 10'b01_0000_0000;
    localparam logic [9:0] SE  = 10'b00_1000_0000;
    localparam logic [9:0] SM  = 10'b00_0100_0000;
    localparam logic [9:0] FD  = 10'b00_0010_0000;
    localparam logic [9:0] FE  = 10'b00_0001_0000;
    localparam logic [9:0] FM  = 10'b00_0000_1000;
    localparam logic [9:0] FW  = 10'b00_0000_0100;
    localparam logic [9:0] BSY = 10'b00_0000_0010;
    localparam logic [9:0] PND = 10'b00_0000_0001;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] d_rs, d_rt, e_writereg;
    logic       d_read_rs, d_read_rt, e_regwrite, e_mem_read, e_is_mfc;
    logic       e_divmul_start, e_is_div, e_redirect, icache_stall, dcache_stall, m_except;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
    logic       divmul_busy, redirect_pending;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl #(.DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn),
        .d_rs(d_rs), .d_rt(d_rt), .d_read_rs(d_read_rs), .d_read_rt(d_read_rt),
        .e_writereg(e_writereg), .e_regwrite(e_regwrite), .e_mem_read(e_mem_read),
        .e_is_mfc(e_is_mfc), .e_divmul_start(e_divmul_start), .e_is_div(e_is_div),
        .e_redirect(e_redirect), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .m_except(m_except),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .divmul_busy(divmul_busy), .redirect_pending(redirect_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] act_vec();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                divmul_busy, redirect_pending};
    endfunction

    task automatic chk(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = act_vec();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Model: E occupancy as an absolute cycle window, "used" marks the instruction
    // already executed until E moves on.
    int cyc = 0;
    int busy_until = 0;
    bit used = 0;
    bit pend_m = 0;

    always @(negedge clk) begin : model
        logic [9:0] exp, act;
        bit fresh, busy, lu, exc_go;
        int lat;
        lat    = e_is_div ? DIV_LAT : MUL_LAT;
        fresh  = e_divmul_start && (cyc >= busy_until) && !used;
        busy   = fresh || (cyc < busy_until);
        lu     = (e_mem_read || e_is_mfc) && e_regwrite && (e_writereg != 0) &&
                 ((d_read_rs && d_rs == e_writereg) || (d_read_rt && d_rt == e_writereg));
        exc_go = m_except && !dcache_stall;
        exp = '0;
        if (resetn) begin
            if (exc_go)            exp = FD | FE | FM | FW;
            else if (dcache_stall) exp = SF | SD | SE | SM | FW;
            else if (busy)         exp = SF | SD | SE | FM;
            else if (lu)           exp = SF | SD | FE;
            else if (e_redirect)   exp = FD | FE;
            else if (icache_stall) exp = SF | FD;
            else if (pend_m)       exp = FD;
            if (busy)   exp |= BSY;
            if (pend_m) exp |= PND;
        end
        act = act_vec();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL model cyc %0d: got %b expected %b", cyc, act, exp);

        if (!resetn || exc_go) begin
            busy_until = 0;
            used = 0;
            pend_m = 0;
        end else begin
            if (fresh) begin
                busy_until = cyc + lat;
                used = 1;
            end else if ((exp & SE) == 0) begin
                used = 0;
            end
            if (!(dcache_stall || busy || lu)) begin
                if (e_redirect && icache_stall) pend_m = 1;
                else if (!icache_stall)         pend_m = 0;
            end
        end
        cyc++;
    end

    task automatic clear_in();
        d_rs = 0; d_rt = 0; d_read_rs = 0; d_read_rt = 0;
        e_writereg = 0; e_regwrite = 0; e_mem_read = 0; e_is_mfc = 0;
        e_divmul_start = 0; e_is_div = 0; e_redirect = 0;
        icache_stall = 0; dcache_stall = 0; m_except = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int nb;
        resetn = 0;
        clear_in();
        tick(); tick();
        settle(); chk("reset_idle", '0);
        tick();
        resetn = 1;
        settle(); chk("post_reset", '0);

        // load-use via rs
        tick();
        e_mem_read = 1; e_regwrite = 1; e_writereg = 5; d_rs = 5; d_read_rs = 1;
        settle(); chk("loaduse_rs", SF | SD | FE);
        tick();
        e_writereg = 0; d_rs = 0;
        settle(); chk("loaduse_r0", '0);
        tick();
        clear_in();
        e_is_mfc = 1; e_regwrite = 1; e_writereg = 9; d_rt = 9; d_read_rt = 1;
        settle(); chk("mfc_rt", SF | SD | FE);
        tick();
        d_read_rt = 0;
        settle(); chk("mfc_noread", '0);
        tick();
        clear_in();

        // plain divide
        e_divmul_start = 1; e_is_div = 1;
        nb = 0;
        for (int i = 1; i <= 33; i++) begin
            settle();
            if (divmul_busy) nb++;
            if (i == 1)  chk("div_first", SF | SD | SE | FM | BSY);
            if (i == 32) chk("div_last", SF | SD | SE | FM | BSY);
            if (i == 33) chk("div_after", '0);
            tick();
        end
        n_checks++;
        if (nb == 32) n_pass++;
        else $display("FAIL div_len: got %0d expected 32", nb);
        clear_in();
        settle(); chk("div_idle", '0);
        tick();

        // multiply
        e_divmul_start = 1; e_is_div = 0;
        nb = 0;
        for (int i = 1; i <= 3; i++) begin
            settle();
            if (divmul_busy) nb++;
            if (i == 3) chk("mul_after", '0);
            tick();
        end
        n_checks++;
        if (nb == 2) n_pass++;
        else $display("FAIL mul_len: got %0d expected 2", nb);
        clear_in();
        tick();

        // divide with dcache stall in cycles 10..12
        e_divmul_start = 1; e_is_div = 1;
        nb = 0;
        for (int i = 1; i <= 33; i++) begin
            dcache_stall = (i >= 10 && i <= 12);
            settle();
            if (divmul_busy) nb++;
            if (i == 11) chk("div_dcache", SF | SD | SE | SM | FW | BSY);
            if (i == 13) chk("div_resume", SF | SD | SE | FM | BSY);
            if (i == 33) chk("div_dc_after", '0);
            tick();
        end
        n_checks++;
        if (nb == 32) n_pass++;
        else $display("FAIL div_dc_len: got %0d expected 32", nb);
        clear_in();
        tick();

        // redirect under icache miss
        icache_stall = 1; e_redirect = 1;
        settle(); chk("redir_icache", FD | FE);
        tick();
        e_redirect = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (i == 0) chk("pend_hold", SF | FD | PND);
            tick();
        end
        icache_stall = 0;
        settle(); chk("pend_release", FD | PND);
        tick();
        settle(); chk("pend_cleared", '0);
        tick();

        // exception waiting on dcache, cancelling a divide
        e_divmul_start = 1; e_is_div = 1;
        tick(); tick(); tick();
        m_except = 1; dcache_stall = 1;
        settle(); chk("exc_wait", SF | SD | SE | SM | FW | BSY);
        tick();
        dcache_stall = 0;
        settle(); chk("exc_flush", FD | FE | FM | FW | BSY);
        tick();
        clear_in();
        settle(); chk("exc_cancel", '0);
        tick();

        // reset mid-divide with a pending redirect
        icache_stall = 1; e_redirect = 1;
        tick();
        e_redirect = 0; e_divmul_start = 1; e_is_div = 1;
        settle(); chk("busy_with_pend", SF | SD | SE | FM | BSY | PND);
        tick(); tick();
        resetn = 0;
        settle(); chk("reset_forced", '0);
        tick();
        settle(); chk("reset_forced2", '0);
        tick();
        resetn = 1;
        clear_in();
        settle(); chk("reset_release", '0);
        tick();
        settle(); chk("reset_release2", '0);
        tick();

        // mixed vectors checked by the model only
        for (int i = 0; i < 400; i++) begin
            d_rs = 5'($urandom_range(0, 3));
            d_rt = 5'($urandom_range(0, 3));
            d_read_rs = 1'($urandom_range(0, 1));
            d_read_rt = 1'($urandom_range(0, 1));
            e_writereg = 5'($urandom_range(0, 3));
            e_regwrite = 1'($urandom_range(0, 1));
            e_mem_read = ($urandom_range(0, 3) == 0);
            e_is_mfc = ($urandom_range(0, 7) == 0);
            e_divmul_start = ($urandom_range(0, 5) == 0);
            e_is_div = ($urandom_range(0, 7) == 0);
            e_redirect = ($urandom_range(0, 3) == 0);
            icache_stall = ($urandom_range(0, 2) == 0);
            dcache_stall = ($urandom_range(0, 5) == 0);
            m_except = ($urandom_range(0, 15) == 0);
            resetn = ($urandom_range(0, 63) != 0);
            tick();
        end
        resetn = 1;
        clear_in();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage pipeline (F, D, E, M, W).
- Drives the per-stage stall and flush inputs of the inter-stage control and data pipeline registers. In each register, flush overrides stall.
- Tracks multi-cycle mul/div occupancy, load-use hazards, cache-miss stalls, branch redirects and exception flushes.
- Remembers a branch redirect that arrives while fetch is blocked by an instruction-cache miss.

Parameters:
- DIV_LAT, 32, E-stage occupancy in cycles for divide (1..63)
- MUL_LAT, 2, E-stage occupancy in cycles for multiply (1..63)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- d_rs  in  5  rs index of instruction in D
- d_rt  in  5  rt index of instruction in D
- d_read_rs  in  1  D instruction reads rs
- d_read_rt  in  1  D instruction reads rt
- e_writereg  in  5  destination register of instruction in E
- e_regwrite  in  1  E instruction writes GPR
- e_mem_read  in  1  E instruction is a load
- e_is_mfc  in  1  E instruction is mfc0 (result late, treated like a load)
- e_divmul_start  in  1  E holds a mul/div (DivMulEn)
- e_is_div  in  1  1 = divide, 0 = multiply; valid with e_divmul_start
- e_redirect  in  1  branch in E resolved, wrong-path instructions sit in F/D
- icache_stall  in  1  fetch miss outstanding
- dcache_stall  in  1  M-stage memory access outstanding
- m_except  in  1  exception/eret committed from M
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold stage register
- flush_d, flush_e, flush_m, flush_w  out  1 each  bubble into D/E/M/W register
- divmul_busy  out  1  mul/div occupancy active (includes start cycle)
- redirect_pending  out  1  stored redirect awaiting icache return

Behaviour:
Reset:
- resetn low at a clk edge clears cnt (6b), done, pend.
- While resetn is low, all outputs are forced to 0.

Definitions:
- start = e_divmul_start & (cnt==0) & ~done
- divmul_busy = start | (cnt!=0)
- lu = (e_mem_read | e_is_mfc) & e_regwrite & (e_writereg!=0) & ((d_read_rs & d_rs==e_writereg) | (d_read_rt & d_rt==e_writereg))

Priority (first match wins; all unlisted outputs are 0):
1. m_except & ~dcache_stall: flush_d, flush_e, flush_m, flush_w = 1. Next cnt = 0, done = 0, pend = 0.
2. dcache_stall (with or without m_except): stall_f/d/e/m = 1, flush_w = 1. m_except waits.
3. divmul_busy: stall_f/d/e = 1, flush_m = 1.
4. lu: stall_f/d = 1, flush_e = 1.
5. e_redirect: flush_d = 1, flush_e = 1. If icache_stall is also high, set pend.
6. icache_stall: stall_f = 1, flush_d = 1.

Pending redirect:
- While pend = 1, rule 6 applies unchanged.
- In the first cycle icache_stall = 0 with pend = 1, and no rule 1–4: assert flush_d and clear pend. This discards the wrong-path fetch.
- redirect_pending = pend.

Mul/div counter:
- On start: cnt <= LAT-1, where LAT = DIV_LAT if e_is_div, else MUL_LAT. If LAT = 1, set done.
- While cnt != 0: decrement every cycle, regardless of dcache_stall. The transition 1→0 sets done.
- done clears at the edge of any cycle with stall_e = 0.
- Result: E is held for exactly LAT cycles (start cycle + LAT-1), and the instruction advances in cycle LAT if no higher rule applies.
- done prevents re-triggering the same instruction.

Further rules:
- e_redirect is ignored (not stored) in any cycle where rule 1–4 matches. It stays asserted until E advances.
- Outputs are combinational from state and inputs. No input-to-output latency; state updates on the next edge.

Test Plan:
- Load-use: e_mem_read=1, e_regwrite=1, e_writereg=5, d_rs=5, d_read_rs=1 → stall_f=stall_d=flush_e=1 for 1 cycle. Same stimulus with e_writereg=0 → all outputs 0.
- Divide: e_divmul_start=1, e_is_div=1 held → divmul_busy, stall_e, flush_m high for exactly 32 cycles. Cycle 33: all 0 and no retrigger. MUL_LAT=2 variant → exactly 2 cycles.
- dcache_stall=1 for 3 cycles during divide cycles 10–12 → stall_m, flush_w high in those cycles; divide still ends after cycle 32.
- Redirect under icache miss: icache_stall=1, e_redirect=1 for 1 cycle → redirect_pending=1. Then icache_stall=1 for 4 more cycles, then 0 → flush_d=1 in the release cycle, then pend=0.
- Exception: m_except=1 with dcache_stall=1 → stall_f/d/e/m=1, flush_w=1. dcache_stall drops → flush_d/e/m/w=1, no stall. An in-flight divide is cancelled (divmul_busy=0 next cycle).
- Reset: resetn=0 mid-divide with pend=1 → outputs 0 during reset. After release, divmul_busy=0 and redirect_pending=0 until a new start.
